// File: rtl/uart_tx_drain_if.sv
// FIFO-to-transmitter bundle for uart_tx_drain.
//   fifo_empty  FIFO empty flag (FIFO -> tx)
//   fifo_rdata  FIFO head byte, valid while fifo_empty=0 (FIFO -> tx)
//   fifo_rd     pop strobe, one cycle per byte (tx -> FIFO)
//   tx          serial line to the pin, idle high
//   tx_busy     frame in progress
//   tx_done     one-cycle pulse after the stop bit
// slave is the transmitter side, master is the FIFO/pin environment.
interface uart_tx_drain_if;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport slave  (input  fifo_empty, fifo_rdata,
                    output fifo_rd, tx, tx_busy, tx_done);
    modport master (output fifo_empty, fifo_rdata,
                    input  fifo_rd, tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that drains a byte FIFO, LSB first.
// Pops a byte whenever the FIFO is non-empty and the transmitter is idle;
// bit timing comes from an internal tick divider and a 16x oversample count.
// Ports:
//   clk   system clock (rising edge)
//   rst   synchronous active-high reset
//   bus   uart_tx_drain_if.slave: fifo_empty/fifo_rdata in,
//         fifo_rd (combinational), tx/tx_busy/tx_done (registered) out
module uart_tx_drain #(
    parameter int CLKS_PER_TICK = 651,
    parameter int OVERSAMPLE    = 16
) (
    input  logic clk,
    input  logic rst,
    uart_tx_drain_if.slave bus
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [3:0]    OS_LAST   = 4'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          tick;
    logic          bit_end;

    assign tick    = (tick_cnt == TICK_LAST);
    assign bit_end = tick && (os_cnt == OS_LAST);

    // Zero-latency pop: the FIFO head is latched on the same edge the
    // FIFO advances its read pointer.
    assign bus.fifo_rd = (state == IDLE) && !bus.fifo_empty && !rst;

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                os_cnt   <= '0;
                if (bus.fifo_rd) begin
                    shreg   <= bus.fifo_rdata;
                    bit_cnt <= '0;
                    state   <= START;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick)
                    os_cnt <= (os_cnt == OS_LAST) ? 4'd0 : os_cnt + 4'd1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            tx_q  <= shreg[0];
                        end
                        DATA: begin
                            // shreg[1] is the next bit once this shift lands
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end else begin
                                tx_q  <= shreg[1];
                            end
                        end
                        STOP: begin
                            state  <= IDLE;
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
